mul_ctrl: RTL and testbench
===========================

Name: mul_ctrl

Overview:
- Sequencing and result-correction stage wrapped around the 32x32 signed Booth multiplier.
- Accepts RV32M multiply requests (MUL/MULH/MULHSU/MULHU) from the ALU issue side over a valid/ready handshake.
- Launches the multiplier with a one-cycle enable pulse, captures its 64-bit signed product on the finish pulse, and applies the unsigned high-word correction.
- Holds the 32-bit result in an output register until the consumer accepts it.

Parameters:
- TAG_W, 5, width of the opaque request tag (destination register index) carried from request to result.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  request valid
- o_ready  out  1  block can accept a request
- i_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- i_a  in  32  rs1 operand
- i_b  in  32  rs2 operand
- i_tag  in  TAG_W  request tag
- i_flush  in  1  discard the in-flight request
- o_mul_en  out  1  one-cycle start pulse to the multiplier
- o_mul_a  out  32  multiplicand to the multiplier (registered i_a)
- o_mul_b  out  32  multiplier operand to the multiplier (registered i_b)
- i_mul_y  in  64  signed product from the multiplier
- i_mul_finish  in  1  one-cycle product-valid pulse from the multiplier
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts the result
- o_result  out  32  result word
- o_tag  out  TAG_W  tag of the result

Behaviour:
- States: IDLE, START, WAIT, FIX, DONE. Encoding is free.
- Reset (i_rst high at a clock edge):
  - state goes to IDLE.
  - o_valid, o_mul_en and the internal drop flag go to 0.
  - o_result, o_tag, o_mul_a and o_mul_b go to 0.
  - Reset wins over every other input in the same cycle.
- o_ready is 1 only in IDLE. It is combinational from state.
- IDLE: on i_valid && o_ready (and no i_flush), register i_op, i_a, i_b and i_tag, clear the drop flag, and go to START.
- START:
  - o_mul_en = 1 for exactly this cycle; o_mul_a and o_mul_b are stable from this cycle until the capture.
  - Next state is WAIT.
- WAIT:
  - o_mul_en = 0.
  - On i_mul_finish, capture i_mul_y into a 64-bit product register and go to FIX. If the drop flag is set, go to IDLE instead and capture nothing.
  - No timeout: the block waits indefinitely.
- FIX: compute the result from the registered operands a, b and the captured product P (all arithmetic mod 2^32):
  - MUL: P[31:0]
  - MULH: P[63:32]
  - MULHSU: P[63:32] + (b[31] ? a : 0)
  - MULHU: P[63:32] + (a[31] ? b : 0) + (b[31] ? a : 0)
  - Load o_result and o_tag, set o_valid = 1, and go to DONE.
- DONE:
  - o_valid = 1.
  - o_result and o_tag hold while i_ready = 0.
  - On i_ready, clear o_valid and go to IDLE. A new request is not accepted in that same cycle because o_ready is still 0.
- Latency:
  - Acceptance edge to START is 1 cycle.
  - The multiplier samples o_mul_en at the end of START and pulses finish 33 cycles after that edge.
  - o_valid rises 2 cycles after the finish pulse (capture edge, then FIX edge). About 36 cycles accept-to-valid with the current multiplier.
  - The block must not count cycles. It relies only on i_mul_finish.
- i_flush:
  - In IDLE it blocks acceptance.
  - In START, WAIT or FIX it sets the drop flag. The multiplier cannot be aborted, so in START/WAIT the block keeps waiting for i_mul_finish and then returns to IDLE with no o_valid.
  - In FIX it returns to IDLE at the next edge.
  - In DONE it clears o_valid and returns to IDLE (the result is discarded).
- An i_mul_finish arriving outside WAIT is ignored.
- Because o_mul_en is driven only in START, at most one multiplication is in flight.

Test Plan:
- MUL: a=3, b=5 -> exactly one o_mul_en pulse; o_valid with o_result=0x0000000F and the request tag; o_valid high exactly 2 cycles after i_mul_finish.
- MULH: a=0xFFFFFFF9 (-7), b=3 -> o_result=0xFFFFFFFF. MUL with the same operands -> 0xFFFFFFEB.
- MULHU: a=b=0xFFFFFFFF -> o_result=0xFFFFFFFE.
- MULHSU: a=b=0xFFFFFFFF -> o_result=0xFFFFFFFF. MULHSU: a=2, b=0x80000000 -> o_result=0x00000001.
- Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid, o_result and o_tag stable, o_ready=0, i_valid ignored. Raise i_ready -> o_valid falls next edge; next request accepted one cycle later.
- Flush and reset:
  - Pulse i_flush in WAIT -> no o_valid; o_ready returns only after i_mul_finish; the next request gives a correct result.
  - Assert i_rst during WAIT -> all outputs 0, o_ready=1 next cycle.

Source files
------------

// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if: request, multiplier-launch and result channels of mul_ctrl
interface mul_ctrl_if #(parameter int TAG_W = 5);
   logic             i_valid;
   logic             o_ready;
   logic [1:0]       i_op;
   logic [31:0]      i_a;
   logic [31:0]      i_b;
   logic [TAG_W-1:0] i_tag;
   logic             i_flush;
   logic             o_mul_en;
   logic [31:0]      o_mul_a;
   logic [31:0]      o_mul_b;
   logic [63:0]      i_mul_y;
   logic             i_mul_finish;
   logic             o_valid;
   logic             i_ready;
   logic [31:0]      o_result;
   logic [TAG_W-1:0] o_tag;
   modport slave (
      input  i_valid, i_op, i_a, i_b, i_tag, i_flush, i_mul_y, i_mul_finish, i_ready,
      output o_ready, o_mul_en, o_mul_a, o_mul_b, o_valid, o_result, o_tag
   );
   modport master (
      output i_valid, i_op, i_a, i_b, i_tag, i_flush, i_mul_y, i_mul_finish, i_ready,
      input  o_ready, o_mul_en, o_mul_a, o_mul_b, o_valid, o_result, o_tag
   );
endinterface

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequences one RV32M multiply through the signed Booth multiplier
// and corrects the high word for the unsigned variants.
module mul_ctrl #(parameter int TAG_W = 5) (
   input logic     i_clk,
   input logic     i_rst,
   mul_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, START, WAIT, FIX, DONE} state_t;
   state_t           state, state_n;
   logic [1:0]       op;
   logic [TAG_W-1:0] tag;
   logic             drop;
   logic             drop_now;
   logic [63:0]      prod;
   logic [31:0]      hi, corr_a, corr_b, fix;
   assign drop_now     = drop | bus.i_flush;
   assign bus.o_ready  = state == IDLE;
   assign bus.o_mul_en = state == START;
   assign bus.o_valid  = state == DONE;
   always_ff @(posedge i_clk)
      if (i_rst) begin
         state        <= IDLE;
         drop         <= 1'b0;
         op           <= '0;
         tag          <= '0;
         prod         <= '0;
         bus.o_mul_a  <= '0;
         bus.o_mul_b  <= '0;
         bus.o_result <= '0;
         bus.o_tag    <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && bus.i_valid && !bus.i_flush) begin
            op          <= bus.i_op;
            tag         <= bus.i_tag;
            bus.o_mul_a <= bus.i_a;
            bus.o_mul_b <= bus.i_b;
            drop        <= 1'b0;
         end else if ((state == START || state == WAIT || state == FIX) && bus.i_flush)
            drop <= 1'b1;
         if (state == WAIT && bus.i_mul_finish && !drop_now)
            prod <= bus.i_mul_y;
         if (state == FIX && !bus.i_flush) begin
            bus.o_result <= fix;
            bus.o_tag    <= tag;
         end
      end
   // the multiplier is signed; an operand with bit 31 set is worth 2^32 more
   // when read as unsigned, which adds the other operand to the high word
   always_comb begin
      hi     = prod[63:32];
      corr_a = bus.o_mul_b[31] ? bus.o_mul_a : 32'd0;
      corr_b = bus.o_mul_a[31] ? bus.o_mul_b : 32'd0;
      fix    = op == 2'd0 ? prod[31:0] :
               op == 2'd1 ? hi :
               op == 2'd2 ? hi + corr_a : hi + corr_a + corr_b;
      state_n = state;
      case (state)
         IDLE:    state_n = bus.i_valid && !bus.i_flush ? START : IDLE;
         START:   state_n = WAIT;
         WAIT:    state_n = !bus.i_mul_finish ? WAIT : drop_now ? IDLE : FIX;
         FIX:     state_n = bus.i_flush ? IDLE : DONE;
         DONE:    state_n = bus.i_ready || bus.i_flush ? IDLE : DONE;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: directed vectors, corner sequences and random requests for mul_ctrl
// against a multiplier model and a wide-arithmetic reference.
module tb_mul_ctrl;
   logic clk, rst;
   int   n_tests, n_fail, extra;
   mul_ctrl_if #(.TAG_W(5)) bus();
   mul_ctrl #(.TAG_W(5)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [4:0]  tag;
      logic [31:0] exp;
      int          bp;
   } vec_t;
   vec_t vecs[7];
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   // multiplier stand-in: finish pulses 33+extra edges after the edge that sampled o_mul_en
   initial begin
      int cnt;
      logic [31:0] ma, mb;
      cnt = 0;
      ma = '0;
      mb = '0;
      bus.i_mul_finish = 1'b0;
      bus.i_mul_y = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.i_mul_finish = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               bus.i_mul_finish = 1'b1;
               bus.i_mul_y = longint'($signed(ma)) * longint'($signed(mb));
            end
         end
         @(negedge clk);
         if (bus.o_mul_en) begin
            cnt = 33 + extra;
            ma = bus.o_mul_a;
            mb = bus.o_mul_b;
         end
      end
   end
   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [32:0] ea, eb;
      logic signed [65:0] p;
      ea = {(op != 2'd3) && a[31], a};
      eb = {(op == 2'd0 || op == 2'd1) && b[31], b};
      p = ea * eb;
      return op == 2'd0 ? p[31:0] : p[63:32];
   endfunction
   function automatic logic [31:0] pick();
      int s;
      s = $urandom_range(0, 7);
      return s == 0 ? 32'h0 : s == 1 ? 32'h1 : s == 2 ? 32'hFFFF_FFFF :
             s == 3 ? 32'h8000_0000 : s == 4 ? 32'h7FFF_FFFF : 32'($urandom);
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] exp, input int bp);
      int en_cnt, fin_cyc, v_cyc;
      bus.i_valid = 1'b1;
      bus.i_op = op;
      bus.i_a = a;
      bus.i_b = b;
      bus.i_tag = tag;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_a = $urandom;
      bus.i_b = $urandom;
      bus.i_tag = 5'($urandom);
      @(negedge clk);
      chk("accept_start", {bus.o_ready, bus.o_mul_en}, 2'b01);
      en_cnt = 1;
      fin_cyc = -1;
      v_cyc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.o_mul_en) en_cnt++;
         if (bus.i_mul_finish) fin_cyc = i;
         if (bus.o_valid) begin
            v_cyc = i;
            break;
         end
      end
      chk("valid_seen", 64'(v_cyc >= 0), 1);
      chk("en_pulses", en_cnt, 1);
      chk("fin_to_valid", v_cyc - fin_cyc, 2);
      chk("result", bus.o_result, exp);
      chk("tag", bus.o_tag, tag);
      bus.i_valid = 1'b1;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         chk("hold", {bus.o_valid, bus.o_ready, bus.o_result, bus.o_tag}, {1'b1, 1'b0, exp, tag});
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.i_ready = 1'b0;
      @(negedge clk);
      chk("release", {bus.o_valid, bus.o_ready, bus.o_mul_en}, 3'b010);
   endtask
   initial begin
      int bad, saw;
      logic [1:0] op;
      logic [31:0] a, b;
      logic [4:0] tag;
      n_tests = 0;
      n_fail = 0;
      extra = 0;
      vecs[0] = '{2'd0, 32'd3, 32'd5, 5'd1, 32'h0000_000F, 0};
      vecs[1] = '{2'd1, 32'hFFFF_FFF9, 32'd3, 5'd2, 32'hFFFF_FFFF, 10};
      vecs[2] = '{2'd0, 32'hFFFF_FFF9, 32'd3, 5'd3, 32'hFFFF_FFEB, 1};
      vecs[3] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 0};
      vecs[4] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 2};
      vecs[5] = '{2'd2, 32'd2, 32'h8000_0000, 5'd6, 32'h0000_0001, 0};
      vecs[6] = '{2'd3, 32'h8000_0000, 32'h8000_0000, 5'd31, 32'h4000_0000, 0};
      rst = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_op = '0;
      bus.i_a = '0;
      bus.i_b = '0;
      bus.i_tag = '0;
      bus.i_flush = 1'b0;
      bus.i_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ctl", {bus.o_ready, bus.o_valid, bus.o_mul_en, bus.o_tag}, {3'b100, 5'd0});
      chk("reset_res", bus.o_result, 0);
      chk("reset_ab", {bus.o_mul_a, bus.o_mul_b}, 0);
      for (int i = 0; i < 7; i++)
         run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, vecs[i].bp);
      bus.i_valid = 1'b1;
      bus.i_flush = 1'b1;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b0;
      @(negedge clk);
      chk("flush_blocks_accept", {bus.o_ready, bus.o_mul_en}, 2'b10);
      bus.i_valid = 1'b1;
      bus.i_op = 2'd0;
      bus.i_a = 32'd6;
      bus.i_b = 32'd7;
      bus.i_tag = 5'd9;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      bus.i_flush = 1'b1;
      @(posedge clk);
      #1;
      bus.i_flush = 1'b0;
      bad = 0;
      saw = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.o_valid || bus.o_ready) bad++;
         if (bus.i_mul_finish) begin
            saw = 1;
            break;
         end
      end
      chk("flush_busy_no_valid", bad, 0);
      chk("flush_fin_seen", saw, 1);
      @(negedge clk);
      chk("flush_idle", {bus.o_valid, bus.o_ready}, 2'b01);
      run(2'd0, 32'd11, 32'd13, 5'd10, 32'd143, 0);
      bus.i_valid = 1'b1;
      bus.i_op = 2'd3;
      bus.i_a = 32'hDEAD_BEEF;
      bus.i_b = 32'h1234_5678;
      bus.i_tag = 5'd17;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("wait_rst_ctl", {bus.o_ready, bus.o_valid, bus.o_mul_en, bus.o_tag}, {3'b100, 5'd0});
      chk("wait_rst_res", bus.o_result, 0);
      chk("wait_rst_ab", {bus.o_mul_a, bus.o_mul_b}, 0);
      bad = 0;
      saw = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.o_valid || !bus.o_ready) bad++;
         if (bus.i_mul_finish) saw = 1;
      end
      chk("stale_fin_ignored", {saw[0], bad}, {1'b1, 32'd0});
      run(2'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd18, ref_mul(2'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF), 0);
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom);
         a = pick();
         b = pick();
         tag = 5'($urandom);
         extra = $urandom_range(0, 4);
         run(op, a, b, tag, ref_mul(op, a, b), $urandom_range(0, 3));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
